// File: rtl/raster_pkg.sv
// rtl/raster_pkg.sv - opcodes, FSM encoding and instruction field layout for the raster engine
package raster_pkg;

    localparam int OP_NOP   = 0;
    localparam int OP_TRI   = 1;
    localparam int OP_RECT  = 2;
    localparam int OP_CLEAR = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic int instr_width(input int xb, input int yb, input int cb,
                                       input int ob, input int mb);
        return ob + mb + 3 * cb + 3 * (xb + yb);
    endfunction

    // Vertex k (1..3) packs {x, y}; vertex 3 sits at the LSB end.
    function automatic int vtx_off(input int k, input int xb, input int yb);
        return (3 - k) * (xb + yb);
    endfunction

    function automatic int rgb_off(input int xb, input int yb);
        return 3 * (xb + yb);
    endfunction

    function automatic int misc_off(input int xb, input int yb, input int cb);
        return 3 * (xb + yb) + 3 * cb;
    endfunction

    function automatic int op_off(input int xb, input int yb, input int cb, input int mb);
        return 3 * (xb + yb) + 3 * cb + mb;
    endfunction

endpackage

// File: rtl/edge_eval.sv
// rtl/edge_eval.sv - three triangle edge functions at a point plus the two-winding coverage flag
module edge_eval #(
    parameter int X_BITS = 4,
    parameter int Y_BITS = 3,
    parameter int EW     = X_BITS + Y_BITS + 3
) (
    input  logic [X_BITS-1:0]     ax,
    input  logic [Y_BITS-1:0]     ay,
    input  logic [X_BITS-1:0]     bx,
    input  logic [Y_BITS-1:0]     by,
    input  logic [X_BITS-1:0]     cx,
    input  logic [Y_BITS-1:0]     cy,
    input  logic [X_BITS-1:0]     px,
    input  logic [Y_BITS-1:0]     py,
    output logic signed [EW-1:0]  e_ab,
    output logic signed [EW-1:0]  e_bc,
    output logic signed [EW-1:0]  e_ca,
    output logic                  covered
);

    function automatic logic signed [EW-1:0] edge_fn(
        input logic signed [EW-1:0] ux, input logic signed [EW-1:0] uy,
        input logic signed [EW-1:0] vx, input logic signed [EW-1:0] vy,
        input logic signed [EW-1:0] qx, input logic signed [EW-1:0] qy);
        return (vx - ux) * (qy - uy) - (vy - uy) * (qx - ux);
    endfunction

    logic signed [EW-1:0] sax, say, sbx, sby, scx, scy, spx, spy;
    logic                 all_ge, all_le;

    always_comb begin
        sax = EW'(ax);
        say = EW'(ay);
        sbx = EW'(bx);
        sby = EW'(by);
        scx = EW'(cx);
        scy = EW'(cy);
        spx = EW'(px);
        spy = EW'(py);
        e_ab = edge_fn(sax, say, sbx, sby, spx, spy);
        e_bc = edge_fn(sbx, sby, scx, scy, spx, spy);
        e_ca = edge_fn(scx, scy, sax, say, spx, spy);
        // Zero counts on both sides so edge pixels are drawn for either winding.
        all_ge  = !e_ab[EW-1] && !e_bc[EW-1] && !e_ca[EW-1];
        all_le  = (e_ab[EW-1] || e_ab == '0) && (e_bc[EW-1] || e_bc == '0)
               && (e_ca[EW-1] || e_ca == '0);
        covered = all_ge || all_le;
    end

endmodule

// File: rtl/raster_engine.sv
// rtl/raster_engine.sv - instruction-driven bounding-box rasterizer streaming covered pixels
module raster_engine
    import raster_pkg::*;
#(
    parameter int X_BITS     = 4,
    parameter int Y_BITS     = 3,
    parameter int COLOR_BITS = 8,
    parameter int OP_BITS    = 2,
    parameter int MISC_BITS  = 9,
    parameter int INSTR_W    = instr_width(X_BITS, Y_BITS, COLOR_BITS, OP_BITS, MISC_BITS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [INSTR_W-1:0]      instruction,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [X_BITS-1:0]       pix_x,
    output logic [Y_BITS-1:0]       pix_y,
    output logic [3*COLOR_BITS-1:0] pix_rgb,
    output logic                    busy,
    output logic                    prim_done
);

    localparam int EW       = X_BITS + Y_BITS + 3;
    localparam int RGB_W    = 3 * COLOR_BITS;
    localparam int V1_OFF   = vtx_off(1, X_BITS, Y_BITS);
    localparam int V2_OFF   = vtx_off(2, X_BITS, Y_BITS);
    localparam int V3_OFF   = vtx_off(3, X_BITS, Y_BITS);
    localparam int RGB_OFF  = rgb_off(X_BITS, Y_BITS);
    localparam int MISC_OFF = misc_off(X_BITS, Y_BITS, COLOR_BITS);
    localparam int OP_OFF   = op_off(X_BITS, Y_BITS, COLOR_BITS, MISC_BITS);

    state_t state, state_nx;

    logic [OP_BITS-1:0] op_q;
    logic [RGB_W-1:0]   rgb_q;
    logic [X_BITS-1:0]  x1_q, x2_q, x3_q, xmin, xmax, cx, bx_lo, bx_hi, ev_px;
    logic [Y_BITS-1:0]  y1_q, y2_q, y3_q, ymin, ymax, cy, by_lo, by_hi, ev_py;

    logic signed [EW-1:0] e_ab, e_bc, e_ca;
    logic tri_cov, is_tri, is_clear, zero_area;
    logic accept, stall, scan_adv, scan_last, load;
    logic unused_bits;

    assign is_tri    = (op_q == OP_BITS'(OP_TRI));
    assign is_clear  = (op_q == OP_BITS'(OP_CLEAR));
    assign accept    = instr_valid && instr_ready;
    assign stall     = pix_valid && !pix_ready;
    assign scan_adv  = (state == S_SCAN) && !stall;
    assign scan_last = (cx == xmax) && (cy == ymax);
    assign load      = scan_adv && (!is_tri || tri_cov);
    assign zero_area = (e_ab == '0);

    // During SETUP the evaluator sees vertex 3, so E_ab(c) is the doubled signed area.
    assign ev_px = (state == S_SETUP) ? x3_q : cx;
    assign ev_py = (state == S_SETUP) ? y3_q : cy;

    edge_eval #(
        .X_BITS (X_BITS),
        .Y_BITS (Y_BITS),
        .EW     (EW)
    ) u_edge_eval (
        .ax      (x1_q),
        .ay      (y1_q),
        .bx      (x2_q),
        .by      (y2_q),
        .cx      (x3_q),
        .cy      (y3_q),
        .px      (ev_px),
        .py      (ev_py),
        .e_ab    (e_ab),
        .e_bc    (e_bc),
        .e_ca    (e_ca),
        .covered (tri_cov)
    );

    assign unused_bits = ^{instruction[MISC_OFF +: MISC_BITS], e_bc, e_ca};

    always_comb begin
        bx_lo = (x1_q < x2_q) ? x1_q : x2_q;
        bx_hi = (x1_q < x2_q) ? x2_q : x1_q;
        by_lo = (y1_q < y2_q) ? y1_q : y2_q;
        by_hi = (y1_q < y2_q) ? y2_q : y1_q;
        if (is_tri) begin
            if (x3_q < bx_lo) bx_lo = x3_q;
            if (x3_q > bx_hi) bx_hi = x3_q;
            if (y3_q < by_lo) by_lo = y3_q;
            if (y3_q > by_hi) by_hi = y3_q;
        end else if (is_clear) begin
            bx_lo = '0;
            bx_hi = '1;
            by_lo = '0;
            by_hi = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_nx = (instruction[OP_OFF +: OP_BITS] == OP_BITS'(OP_NOP)) ? S_DONE : S_SETUP;
            end
            S_SETUP: state_nx = (is_tri && zero_area) ? S_DONE : S_SCAN;
            S_SCAN:  if (scan_adv && scan_last) state_nx = S_DRAIN;
            S_DRAIN: if (!pix_valid || pix_ready) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state == S_IDLE);
        busy        = (state != S_IDLE);
        prim_done   = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            rgb_q     <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            x2_q      <= '0;
            y2_q      <= '0;
            x3_q      <= '0;
            y3_q      <= '0;
            xmin      <= '0;
            xmax      <= '0;
            ymin      <= '0;
            ymax      <= '0;
            cx        <= '0;
            cy        <= '0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_rgb   <= '0;
        end else begin
            if (accept) begin
                op_q  <= instruction[OP_OFF +: OP_BITS];
                rgb_q <= instruction[RGB_OFF +: RGB_W];
                x1_q  <= instruction[V1_OFF + Y_BITS +: X_BITS];
                y1_q  <= instruction[V1_OFF +: Y_BITS];
                x2_q  <= instruction[V2_OFF + Y_BITS +: X_BITS];
                y2_q  <= instruction[V2_OFF +: Y_BITS];
                x3_q  <= instruction[V3_OFF + Y_BITS +: X_BITS];
                y3_q  <= instruction[V3_OFF +: Y_BITS];
            end
            if (state == S_SETUP) begin
                xmin <= bx_lo;
                xmax <= bx_hi;
                ymin <= by_lo;
                ymax <= by_hi;
                cx   <= bx_lo;
                cy   <= by_lo;
            end else if (scan_adv && !scan_last) begin
                // Compare before incrementing so a bbox at the screen edge never wraps.
                if (cx == xmax) begin
                    cx <= xmin;
                    cy <= cy + Y_BITS'(1);
                end else begin
                    cx <= cx + X_BITS'(1);
                end
            end
            if (load) begin
                pix_valid <= 1'b1;
                pix_x     <= cx;
                pix_y     <= cy;
                pix_rgb   <= rgb_q;
            end else if (pix_valid && pix_ready) begin
                pix_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_raster_engine.sv
// tb/tb_raster_engine.sv - directed self-checking bench for raster_engine
module tb_raster_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [55:0] instruction = '0;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [3:0]  pix_x;
    logic [2:0]  pix_y;
    logic [23:0] pix_rgb;
    logic        busy;
    logic        prim_done;

    raster_engine dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_rgb     (pix_rgb),
        .busy        (busy),
        .prim_done   (prim_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    logic [30:0] got[$];
    logic [30:0] expq[$];
    int acc_cyc, first_cyc, last_hs, done_cyc, ndone, stab_err, rdy_err, mism;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] mk(input int op, input logic [23:0] rgb,
                                       input int x1, input int y1, input int x2,
                                       input int y2, input int x3, input int y3);
        return {2'(op), 9'h1a5, rgb, 4'(x1), 3'(y1), 4'(x2), 3'(y2), 4'(x3), 3'(y3)};
    endfunction

    function automatic logic [30:0] pk(input int x, input int y, input logic [23:0] rgb);
        return {4'(x), 3'(y), rgb};
    endfunction

    task automatic send(input logic [55:0] ins);
        @(negedge clk);
        instruction = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        acc_cyc = cyc;
        got.delete();
    endtask

    // mode 0: pix_ready always high; mode 1: pix_ready toggles every cycle.
    task automatic run(input int mode, input int budget, input logic hold_valid);
        int n;
        logic fin, was_stall;
        logic [30:0] held;
        n = 0; fin = 1'b0; was_stall = 1'b0; held = '0;
        ndone = 0; done_cyc = -1; last_hs = -1; first_cyc = -1; stab_err = 0; rdy_err = 0;
        instr_valid = hold_valid;
        while (!fin && n < budget) begin
            pix_ready = (mode == 0) ? 1'b1 : cyc[0];
            if (was_stall && (!pix_valid || {pix_x, pix_y, pix_rgb} !== held)) stab_err++;
            was_stall = pix_valid && !pix_ready;
            held = {pix_x, pix_y, pix_rgb};
            if (pix_valid && first_cyc < 0) first_cyc = cyc;
            if (pix_valid && pix_ready) begin
                got.push_back({pix_x, pix_y, pix_rgb});
                last_hs = cyc;
            end
            if (busy && instr_ready) rdy_err++;
            if (prim_done) begin
                ndone++;
                done_cyc = cyc;
                instr_valid = 1'b0;
                fin = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        instr_valid = 1'b0;
    endtask

    task automatic compare_q(input string tag);
        mism = 0;
        for (int i = 0; i < expq.size(); i++)
            if (i >= got.size() || got[i] !== expq[i]) mism++;
        check({tag, "_count"}, got.size(), expq.size());
        check({tag, "_seq"}, mism, 0);
    endtask

    initial begin
        // 1: reset state
        repeat (2) @(negedge clk);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_instr_ready", instr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_prim_done", prim_done, 0);
        check("rst_pix_xyrgb", {pix_x, pix_y, pix_rgb}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_pix_valid", pix_valid, 0);

        // 2: RECT with swapped corners
        send(mk(2, 24'hFF0000, 2, 2, 1, 1, 7, 7));
        run(0, 100, 1'b0);
        check("rect_done", ndone, 1);
        check("rect_latency", first_cyc - acc_cyc, 2);
        check("rect_p0", got.size() > 0 ? got[0] : 31'h0, pk(1, 1, 24'hFF0000));
        check("rect_p1", got.size() > 1 ? got[1] : 31'h0, pk(2, 1, 24'hFF0000));
        check("rect_p2", got.size() > 2 ? got[2] : 31'h0, pk(1, 2, 24'hFF0000));
        check("rect_p3", got.size() > 3 ? got[3] : 31'h0, pk(2, 2, 24'hFF0000));
        check("rect_count", got.size(), 4);
        check("rect_done_after_hs", done_cyc - last_hs, 1);
        @(negedge clk);
        check("rect_done_pulse", prim_done, 0);
        check("rect_ready_back", instr_ready, 1);

        // 3: triangle, both windings
        expq.delete();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                if (x + y <= 3) expq.push_back(pk(x, y, 24'h123456));
        send(mk(1, 24'h123456, 0, 0, 3, 0, 0, 3));
        run(0, 100, 1'b0);
        check("tri_ccw_done", ndone, 1);
        compare_q("tri_ccw");
        send(mk(1, 24'h123456, 0, 0, 0, 3, 3, 0));
        run(0, 100, 1'b0);
        check("tri_cw_done", ndone, 1);
        compare_q("tri_cw");

        // 4: collinear triangle
        send(mk(1, 24'hABCDEF, 0, 0, 2, 2, 4, 4));
        check("zero_setup_busy", busy, 1);
        @(negedge clk);
        check("zero_prim_done", prim_done, 1);
        check("zero_no_pixel", pix_valid, 0);
        @(negedge clk);
        check("zero_ready_back", instr_ready, 1);
        check("zero_done_pulse", prim_done, 0);

        // 5: CLEAR under toggling backpressure, with a competing instruction held valid
        expq.delete();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 16; x++)
                expq.push_back(pk(x, y, 24'h00FF00));
        send(mk(3, 24'h00FF00, 9, 9, 9, 9, 9, 9));
        instruction = mk(2, 24'h0000FF, 5, 5, 5, 5, 0, 0);
        run(1, 1000, 1'b1);
        check("clr_done", ndone, 1);
        compare_q("clr");
        check("clr_stable", stab_err, 0);
        check("clr_busy_ignore", rdy_err, 0);
        pix_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("clr_idle_after", busy, 0);
        check("clr_no_extra_pix", pix_valid, 0);

        // 6: reset mid-scan
        send(mk(3, 24'h00FF00, 0, 0, 0, 0, 0, 0));
        run(0, 10, 1'b0);
        check("mid_no_done", ndone, 0);
        check("mid_pix_valid", pix_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_pix_valid", pix_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_prim_done", prim_done, 0);
        check("rst_mid_xy", {pix_x, pix_y}, 0);
        reset = 1'b0;
        mism = 0;
        repeat (3) begin
            @(negedge clk);
            if (prim_done || busy || pix_valid) mism++;
        end
        check("rst_mid_quiet", mism, 0);
        send(mk(2, 24'hC0FFEE, 0, 0, 0, 0, 3, 3));
        run(0, 50, 1'b0);
        check("post_rst_done", ndone, 1);
        check("post_rst_count", got.size(), 1);
        check("post_rst_pix", got.size() > 0 ? got[0] : 31'h0, pk(0, 0, 24'hC0FFEE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
